gamma_decoder: RTL and testbench
================================

# gamma_decoder

Sequential additive-gamma decoder, the receive-side counterpart of the gamma coder's adder path. It accepts ciphertext bytes over a valid/ready stream and regenerates the same 8-bit gamma sequence from a loaded seed. Each byte is recovered as plaintext = ciphertext − gamma (mod 256), and plaintext leaves on a registered valid/ready stream.

## Interface
Parameters:
- `A_MULT`, default 8'd5: LCG multiplier. Must satisfy A ≡ 1 mod 4 for full period.
- `C_INC`, default 8'd3: LCG increment. Must be odd.

Ports:
- `clk`, in, 1: single clock. All state is updated on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `seed_load`, in, 1: one-cycle pulse that loads `seed` and starts or restarts a stream.
- `seed`, in, 8: gamma seed g0.
- `s_valid`, in, 1: ciphertext byte present.
- `s_ready`, out, 1: decoder accepts the byte this cycle.
- `s_data`, in, 8: ciphertext byte.
- `m_valid`, out, 1: plaintext byte present.
- `m_ready`, in, 1: downstream accepts the plaintext byte.
- `m_data`, out, 8: plaintext byte.
- `checksum`, out, 8: only with `GAMMA_DECODER_CHECKSUM_EN`.

## Operation
- **FSM states**
  - IDLE: no seed loaded; `s_ready`=0.
  - RUN: decoding.
- **Transitions**
  - Any state, `seed_load`=1 → RUN. Effects: gamma ← `seed`, `m_valid` ← 0 (a pending output byte is discarded).
  - `rst` → IDLE.
  - No other transitions.
- **Gamma sequence:** byte k (counted from the last seed load) uses g_k, where g_0 = seed and g_{k+1} = (A_MULT·g_k + C_INC) mod 256. Multiply and add are truncated to 8 bits.
- **Accept condition:** state == RUN && `s_valid` && `s_ready`.
  - `s_ready` = (state == RUN) && !`seed_load` && (!`m_valid` || `m_ready`).
- **On accept:**
  - `m_data` ← `s_data` + ~g + 1, borrow discarded (8-bit wrap).
  - gamma ← g_{k+1}.
  - `m_valid` ← 1.
- **Hold:** `m_valid` && !`m_ready` → `m_data` and `m_valid` are held stable. No new byte is accepted.
- **Output completion:** `m_valid` && `m_ready` with no new accept → `m_valid` ← 0.
- **Simultaneous events:**
  - `seed_load` with `s_valid`: `seed_load` wins. The byte is not accepted (`s_ready`=0) and must be re-presented.
  - `seed_load` with an output handshake: the output byte counts as delivered; `m_valid` ← 0.
- **Gamma advance rule:** gamma advances only on accept, never on stall or idle cycles.

## Timing
- Reset values: state=IDLE, gamma=0, `m_valid`=0, `m_data`=0, `s_ready`=0, `checksum`=0.
- Latency: accept at edge N → `m_valid`=1 with `m_data` valid after edge N.
- Throughput: 1 byte/cycle while `m_ready`=1 (pass-through pipeline register).
- `s_ready` is combinational from state, `m_valid`, `m_ready`, `seed_load`. It has no path from `s_valid` or `s_data`.
- `seed_load` takes effect at the next edge; the first byte can be accepted the cycle after.
- `rst` mid-stream: all state is cleared at that edge. A new `seed_load` is required before any byte is accepted.

## Configuration
- **`GAMMA_DECODER_CHECKSUM_EN` defined:**
  - Port `checksum` exists: 8-bit running sum (mod 256) of all plaintext bytes produced since the last `seed_load`/`rst`.
  - It is updated on the same edge that loads `m_data`, so it includes the byte currently in `m_data`.
  - Cleared to 0 by `rst` and `seed_load`.
- **Undefined:** port and logic are absent; all other behaviour is identical.

## Structure
- **Package `gamma_pkg`:**
  - `GAMMA_W`=8.
  - `byte_t` typedef.
  - Default `A_MULT`/`C_INC` constants.
  - `dec_state_t` enum {IDLE, RUN}.
  - These are shared with the coder side so both ends generate identical gamma.
- **Sub-module `gamma_lcg`:**
  - Inputs: `clk`, `rst`, load, seed, step.
  - Output: current gamma.
  - Holds the gamma register and next-value logic.
- **`gamma_decoder` top:** FSM, handshake, subtract, output register, optional checksum.

## Test plan
- **Basic decode:** `rst`, then `seed_load` seed=0x10, then cipher 0x15, 0x53, 0xA1 with `m_ready`=1 → `m_data` 0x05, 0x00, 0xFF, each 1 cycle after accept. Gamma is 0x10, 0x53, 0xA2; next g3=0x2D. Checksum (when enabled) = 0x04.
- **No seed:** after `rst`, `s_valid`=1 for 10 cycles → `s_ready`=0 throughout, `m_valid`=0.
- **Backpressure:** seed 0x10, cipher 0x15 then 0x53, `m_ready`=0 for 4 cycles.
  - `m_valid`=1 and `m_data`=0x05 are held; `s_ready`=0; gamma stays 0x53.
  - Raise `m_ready` → 0x00 follows in the next cycle.
- **Reseed mid-stream:** with `m_valid`=1 pending (stalled), pulse `seed_load` seed=0x00 while `s_valid`=1.
  - Byte not accepted; `m_valid`→0.
  - Re-presented cipher 0x07 → `m_data`=0x07; next cipher 0x03 → 0x00 (g1=0x03).
- **Reset mid-operation:** `rst` during streaming → all outputs are at reset values next cycle; no further accepts until `seed_load`.
- **Wrap:** seed 0xFF, cipher 0x00 → `m_data` 0x01. Next gamma is (5·0xFF+3) mod 256 = 0xFE; cipher 0xFE → `m_data` 0x00.

Source files
------------

// File: rtl/gamma_pkg.sv
// Shared gamma definitions used by both the coder and decoder so that the
// two ends generate an identical gamma sequence.
package gamma_pkg;

  localparam int GAMMA_W = 8;

  typedef logic [GAMMA_W-1:0] byte_t;

  localparam byte_t A_MULT_DEF = 8'd5;
  localparam byte_t C_INC_DEF  = 8'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/gamma_lcg.sv
// 8-bit linear congruential gamma generator: g_{k+1} = A*g_k + C (mod 256).
// Loads the seed on load, advances only on step.
module gamma_lcg
  import gamma_pkg::*;
#(
  parameter byte_t A_MULT = A_MULT_DEF,
  parameter byte_t C_INC  = C_INC_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  byte_t seed,
  input  logic  step,
  output byte_t gamma
);

  byte_t gamma_r;
  byte_t gamma_next_s;

  // Product and sum are both truncated to the gamma width.
  assign gamma_next_s = (A_MULT * gamma_r) + C_INC;
  assign gamma        = gamma_r;

  // Gamma register: load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      gamma_r <= 8'd0;
    end else if (load) begin
      gamma_r <= seed;
    end else if (step) begin
      gamma_r <= gamma_next_s;
    end
  end

endmodule

// File: rtl/gamma_decoder.sv
// Additive-gamma stream decoder: plaintext = ciphertext - gamma (mod 256).
// Optional running plaintext checksum port enabled by GAMMA_DECODER_CHECKSUM_EN.
module gamma_decoder
  import gamma_pkg::*;
#(
  parameter byte_t A_MULT = A_MULT_DEF,
  parameter byte_t C_INC  = C_INC_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  seed_load,
  input  byte_t seed,
  input  logic  s_valid,
  output logic  s_ready,
  input  byte_t s_data,
  output logic  m_valid,
  input  logic  m_ready,
  output byte_t m_data
`ifdef GAMMA_DECODER_CHECKSUM_EN
  ,
  output byte_t checksum
`endif
);

  dec_state_t state_r;
  dec_state_t next_state_s;
  logic       m_valid_r;
  byte_t      m_data_r;
  byte_t      gamma_s;
  byte_t      plain_s;
  logic       s_ready_s;
  logic       accept_s;

  // A reseed cycle never accepts, so the byte must be re-presented afterwards.
  assign s_ready_s = (state_r == RUN) && !seed_load && (!m_valid_r || m_ready);
  assign accept_s  = (state_r == RUN) && s_valid && s_ready_s;
  assign plain_s   = s_data + ~gamma_s + 8'd1;

  assign s_ready = s_ready_s;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;

  gamma_lcg #(
    .A_MULT (A_MULT),
    .C_INC  (C_INC)
  ) u_lcg (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_load),
    .seed  (seed),
    .step  (accept_s),
    .gamma (gamma_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: seed_load enters RUN from any state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (seed_load) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        next_state_s = RUN;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output register; a reseed discards any pending byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_data_r  <= 8'd0;
    end else if (seed_load) begin
      m_valid_r <= 1'b0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= plain_s;
    end else if (m_valid_r && m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

`ifdef GAMMA_DECODER_CHECKSUM_EN
  byte_t checksum_r;

  assign checksum = checksum_r;

  // Running sum updated on the same edge that loads m_data.
  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      checksum_r <= 8'd0;
    end else if (accept_s) begin
      checksum_r <= checksum_r + plain_s;
    end
  end
`endif

endmodule

// File: tb/tb_gamma_decoder.sv
// Directed self-checking bench for gamma_decoder: a vector table plus
// hand-written reset / no-seed / reset-mid-stream sequences.
module tb_gamma_decoder;

  logic       clk;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef GAMMA_DECODER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int n_tests;
  int n_fail;

  gamma_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef GAMMA_DECODER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sl;
    logic [7:0] sd;
    logic       sv;
    logic [7:0] dat;
    logic       mr;
    logic       e_rdy;
    logic       e_mv;
    logic [7:0] e_md;
    logic [7:0] e_cs;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sl, input logic [7:0] sd, input logic sv,
                       input logic [7:0] dat, input logic mr);
    seed_load = sl;
    seed      = sd;
    s_valid   = sv;
    s_data    = dat;
    m_ready   = mr;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    //                 sl    seed   sv    data   mr    rdy   mv    md     cs
    // basic decode: gamma 10,53,A2
    vecs[0]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h15, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b1, 1'b1, 1'b1, 8'h00, 8'h05};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h04};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h04};
    // backpressure: 4 stalled cycles, gamma must stay at 0x53
    vecs[5]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 8'h05, 8'h05};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b1, 1'b1, 1'b1, 8'h00, 8'h05};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05};
    // reseed while stalled and s_valid high: byte not accepted, pending dropped
    vecs[13] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 8'h05, 8'h05};
    vecs[15] = '{1'b1, 8'h00, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 8'h07};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h00, 8'h07};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h07};
    // wrap: seed FF, next gamma FE; reseed coincident with output handshake
    vecs[19] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01};
    vecs[21] = '{1'b1, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00};
    vecs[22] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b1, 8'h00, 8'h01};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", {7'd0, m_valid}, 8'h00);
    chk("reset_m_data", m_data, 8'h00);
    chk("reset_s_ready", {7'd0, s_ready}, 8'h00);
`ifdef GAMMA_DECODER_CHECKSUM_EN
    chk("reset_checksum", checksum, 8'h00);
`endif

    // no seed loaded: s_valid high for 10 cycles, nothing accepted
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 8'h15, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("noseed_s_ready", {7'd0, s_ready}, 8'h00);
      @(posedge clk);
      #1;
      chk("noseed_m_valid", {7'd0, m_valid}, 8'h00);
      @(negedge clk);
    end

    // vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].sl, vecs[i].sd, vecs[i].sv, vecs[i].dat, vecs[i].mr);
      #1;
      chk($sformatf("v%0d_s_ready", i), {7'd0, s_ready}, {7'd0, vecs[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_m_valid", i), {7'd0, m_valid}, {7'd0, vecs[i].e_mv});
      chk($sformatf("v%0d_m_data", i), m_data, vecs[i].e_md);
`ifdef GAMMA_DECODER_CHECKSUM_EN
      chk($sformatf("v%0d_checksum", i), checksum, vecs[i].e_cs);
`endif
    end

    // reset mid-operation with a pending stalled byte
    @(negedge clk);
    drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 8'h15, 1'b0);
    @(posedge clk);
    #1;
    chk("rstmid_pre_m_data", m_data, 8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_m_valid", {7'd0, m_valid}, 8'h00);
    chk("rstmid_m_data", m_data, 8'h00);
    chk("rstmid_s_ready", {7'd0, s_ready}, 8'h00);
`ifdef GAMMA_DECODER_CHECKSUM_EN
    chk("rstmid_checksum", checksum, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 8'h15, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstmid_noaccept_s_ready", {7'd0, s_ready}, 8'h00);
      @(posedge clk);
      #1;
      chk("rstmid_noaccept_m_valid", {7'd0, m_valid}, 8'h00);
      @(negedge clk);
    end
    // reseed after reset: sequence restarts from the new seed
    drive(1'b1, 8'h10, 1'b1, 8'h15, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 8'h15, 1'b1);
    @(posedge clk);
    #1;
    chk("rstmid_reseed_m_data", m_data, 8'h05);
    chk("rstmid_reseed_m_valid", {7'd0, m_valid}, 8'h01);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
